// File: rtl/md_unit_if.sv
// Operand/result bundle between the E stage and the multiply/divide unit.
interface md_unit_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        md_stall;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, md_op, A, B,
        input  busy, md_stall, HI, LO
    );

    modport slave (
        input  start, md_op, A, B,
        output busy, md_stall, HI, LO
    );
endinterface

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: fixed-latency MULT/MULTU/DIV/DIVU, MTHI/MTLO, and HI/LO ownership.
// state  | meaning
// S_IDLE | no operation in flight; MTHI/MTLO and new md ops accepted
// S_RUN  | result held in pending registers, counter running down to commit
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic       clk,
    input logic       reset,
    md_unit_if.slave  md
);
    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        is_arith;
    logic        issue;
    logic        is_mul;
    logic        op_signed;
    logic signed [32:0] mul_a;
    logic signed [32:0] mul_b;
    logic [63:0] mul_p;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] div_b;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic [31:0] quot;
    logic [31:0] rem;

    assign is_arith  = md.start && (md.md_op inside {[3'd1:3'd4]});
    assign issue     = is_arith && (state_q == S_IDLE);
    assign is_mul    = (md.md_op == 3'd1) || (md.md_op == 3'd2);
    assign op_signed = (md.md_op == 3'd1) || (md.md_op == 3'd3);

    // A 33-bit extension lets one signed multiplier serve both MULT and MULTU.
    assign mul_a = {op_signed & md.A[31], md.A};
    assign mul_b = {op_signed & md.B[31], md.B};
    assign mul_p = 64'(mul_a) * 64'(mul_b);

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 with no special case.
    assign a_neg = op_signed & md.A[31];
    assign b_neg = op_signed & md.B[31];
    assign mag_a = a_neg ? (~md.A + 32'd1) : md.A;
    assign mag_b = b_neg ? (~md.B + 32'd1) : md.B;
    assign div_b = (md.B == 32'd0) ? 32'd1 : mag_b;
    assign div_q = mag_a / div_b;
    assign div_r = mag_a % div_b;
    assign quot  = (a_neg ^ b_neg) ? (~div_q + 32'd1) : div_q;
    assign rem   = a_neg ? (~div_r + 32'd1) : div_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    state_d   = S_RUN;
                    cnt_d     = is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                    pend_hi_d = is_mul ? mul_p[63:32] : rem;
                    pend_lo_d = is_mul ? mul_p[31:0]  : quot;
                    pend_wr_d = is_mul || (md.B != 32'd0);
                end else if (md.start && (md.md_op == 3'd5)) begin
                    hi_d = md.A;
                end else if (md.start && (md.md_op == 3'd6)) begin
                    lo_d = md.A;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        md.busy     = (state_q == S_RUN);
        md.md_stall = (state_q == S_RUN) || is_arith;
        md.HI       = hi_q;
        md.LO       = lo_q;
    end
endmodule

// File: tb/tb_md_unit.sv
// Directed plus random stimulus for md_unit, checked against an arithmetic reference model.
module tb_md_unit;
    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    logic clk;
    logic reset;
    md_unit_if md_if ();

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          m_cnt = 0;
    bit          m_wr  = 1'b0;
    logic [31:0] m_hi  = '0;
    logic [31:0] m_lo  = '0;
    logic [31:0] m_phi = '0;
    logic [31:0] m_plo = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic predict(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, sq, sr;
        logic [63:0] p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        m_wr = 1'b1;
        case (op)
            3'd1: begin p = 64'(sa * sb); m_phi = p[63:32]; m_plo = p[31:0]; m_cnt = MULT_N; end
            3'd2: begin p = 64'(a) * 64'(b); m_phi = p[63:32]; m_plo = p[31:0]; m_cnt = MULT_N; end
            3'd3: begin
                m_cnt = DIV_N;
                if (b == 32'd0) m_wr = 1'b0;
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    m_plo = sq[31:0];
                    m_phi = sr[31:0];
                end
            end
            default: begin
                m_cnt = DIV_N;
                if (b == 32'd0) m_wr = 1'b0;
                else begin
                    m_plo = a / b;
                    m_phi = a % b;
                end
            end
        endcase
    endtask

    // One clock: apply inputs, check md_stall, advance the model across the edge, check state.
    task automatic step(input logic s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic exp_stall;
        md_if.start = s;
        md_if.md_op = op;
        md_if.A     = a;
        md_if.B     = b;
        #1;
        exp_stall = (m_cnt > 0) || (s && op >= 3'd1 && op <= 3'd4);
        chk("md_stall", {31'd0, md_if.md_stall}, {31'd0, exp_stall});
        @(posedge clk);
        if (reset) begin
            m_cnt = 0; m_wr = 1'b0; m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0;
        end else if (m_cnt > 0) begin
            if (m_cnt == 1 && m_wr) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
            m_cnt--;
        end else if (s) begin
            if (op >= 3'd1 && op <= 3'd4) predict(op, a, b);
            else if (op == 3'd5) m_hi = a;
            else if (op == 3'd6) m_lo = a;
        end
        #1;
        chk("busy", {31'd0, md_if.busy}, {31'd0, m_cnt > 0});
        chk("HI", md_if.HI, m_hi);
        chk("LO", md_if.LO, m_lo);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, $urandom, $urandom);
    endtask

    initial begin
        md_if.start = 1'b0;
        md_if.md_op = 3'd0;
        md_if.A     = '0;
        md_if.B     = '0;
        reset = 1'b1;
        @(posedge clk);
        step(1'b0, 3'd0, '0, '0);
        reset = 1'b0;
        chk("reset_hi_const", md_if.HI, 32'h0);
        chk("reset_lo_const", md_if.LO, 32'h0);

        // Reset aborts a DIV in flight.
        step(1'b1, 3'd3, 32'd100, 32'd7);
        idle(3);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        chk("abort_busy", {31'd0, md_if.busy}, 32'd0);
        chk("abort_lo", md_if.LO, 32'h0);
        step(1'b1, 3'd6, 32'h1234, '0);
        chk("mtlo_after_reset", md_if.LO, 32'h0000_1234);
        step(1'b1, 3'd5, 32'hCAFE_0001, '0);
        chk("mthi", md_if.HI, 32'hCAFE_0001);

        // Signed multiply, then a few idle cycles to see md_stall drop.
        step(1'b1, 3'd1, 32'hFFFF_FFFD, 32'd5);
        idle(MULT_N + 1);
        chk("mult_hi", md_if.HI, 32'hFFFF_FFFF);
        chk("mult_lo", md_if.LO, 32'hFFFF_FFF1);

        // MULTU followed by a DIV issued in the cycle busy falls.
        step(1'b1, 3'd2, 32'hFFFF_FFFF, 32'd2);
        idle(MULT_N);
        chk("multu_hi", md_if.HI, 32'h0000_0001);
        chk("multu_lo", md_if.LO, 32'hFFFF_FFFE);
        step(1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2);
        chk("b2b_busy", {31'd0, md_if.busy}, 32'd1);
        idle(DIV_N);
        chk("div_lo", md_if.LO, 32'hFFFF_FFFD);
        chk("div_hi", md_if.HI, 32'hFFFF_FFFF);

        step(1'b1, 3'd4, 32'hFFFF_FFF9, 32'd2);
        idle(DIV_N);
        chk("divu_lo", md_if.LO, 32'h7FFF_FFFC);
        chk("divu_hi", md_if.HI, 32'h0000_0001);

        step(1'b1, 3'd4, 32'd7, 32'd0);
        idle(DIV_N);
        chk("divu0_lo", md_if.LO, 32'h7FFF_FFFC);
        chk("divu0_hi", md_if.HI, 32'h0000_0001);

        step(1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(DIV_N);
        chk("divovf_lo", md_if.LO, 32'h8000_0000);
        chk("divovf_hi", md_if.HI, 32'h0000_0000);

        // Start requests while busy must not disturb the in-flight MULT.
        step(1'b1, 3'd1, 32'd1000, 32'd3000);
        step(1'b1, 3'd6, 32'hDEAD_BEEF, '0);
        step(1'b1, 3'd3, 32'd9, 32'd3);
        idle(MULT_N - 2);
        chk("protect_lo", md_if.LO, 32'd3_000_000);
        chk("protect_hi", md_if.HI, 32'd0);

        for (int i = 0; i < 120; i++) begin
            logic [31:0] a, b;
            a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 :
                ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
            step($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), a, b);
        end
        idle(DIV_N + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
